// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline definitions for the hazard/steering unit.
package hazard_ctrl_unit_pkg;

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } hz_state_t;

    localparam logic CTRL_PASS   = 1'b1;
    localparam logic CTRL_BUBBLE = 1'b0;

    localparam int HZ_REG_ADDR_W = 5;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// ID/EX hazard inputs and front-end steering outputs.
interface hazard_ctrl_unit_if
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_W = HZ_REG_ADDR_W
);

    logic [REG_ADDR_W-1:0] rs1_id;
    logic [REG_ADDR_W-1:0] rs2_id;
    logic                  uses_rs1_id;
    logic                  uses_rs2_id;
    logic [REG_ADDR_W-1:0] rd_ex;
    logic                  memRead_ex;
    logic                  branch_taken_ex;
    logic                  jump_ex;

    logic                  ctrl_select;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  pc_src_sel;
    logic [15:0]           stall_count;

    modport master (
        output rs1_id, rs2_id, uses_rs1_id, uses_rs2_id,
        output rd_ex, memRead_ex, branch_taken_ex, jump_ex,
        input  ctrl_select, pc_write, ifid_write,
        input  ifid_flush, pc_src_sel, stall_count
    );

    modport slave (
        input  rs1_id, rs2_id, uses_rs1_id, uses_rs2_id,
        input  rd_ex, memRead_ex, branch_taken_ex, jump_ex,
        output ctrl_select, pc_write, ifid_write,
        output ifid_flush, pc_src_sel, stall_count
    );

endinterface

// File: rtl/hazard_ctrl_unit_hz_match.sv
// Load-use comparator; x0 never matches.
module hz_match
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_W = HZ_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  uses_rs1,
    input  logic                  uses_rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  mem_read,
    output logic                  hz
);

    logic hit1;
    logic hit2;

    assign hit1 = uses_rs1 && (rs1 == rd);
    assign hit2 = uses_rs2 && (rs2 == rd);
    assign hz   = mem_read && (rd != '0) && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall and branch/jump flush steering beside ID.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_W        = HZ_REG_ADDR_W,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_ctrl_unit_if.slave     bus
);

    hz_state_t             state, state_nxt;
    logic [1:0]            cnt, cnt_nxt;
    logic [REG_ADDR_W-1:0] ld_rd, ld_rd_nxt;
    logic [15:0]           stall_count;
    logic                  hz;
    logic                  fl;

    hz_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
        .rs1      (bus.rs1_id),
        .rs2      (bus.rs2_id),
        .uses_rs1 (bus.uses_rs1_id),
        .uses_rs2 (bus.uses_rs2_id),
        .rd       (bus.rd_ex),
        .mem_read (bus.memRead_ex),
        .hz       (hz)
    );

    assign fl = bus.branch_taken_ex || bus.jump_ex;

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        ld_rd_nxt       = ld_rd;
        bus.ctrl_select = CTRL_PASS;
        bus.pc_write    = 1'b1;
        bus.ifid_write  = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.pc_src_sel  = 1'b0;
        if (rst) begin
            bus.ctrl_select = CTRL_BUBBLE;
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
        end else if (fl) begin
            // squash wrong path; any pending stall is moot
            bus.ctrl_select = CTRL_BUBBLE;
            bus.ifid_flush  = 1'b1;
            bus.pc_src_sel  = 1'b1;
            state_nxt       = RUN;
            cnt_nxt         = 2'd0;
        end else if (state == LOAD_STALL) begin
            bus.ctrl_select = CTRL_BUBBLE;
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            if (cnt == 2'd0) state_nxt = RUN;
            else             cnt_nxt   = cnt - 2'd1;
        end else if (hz) begin
            bus.ctrl_select = CTRL_BUBBLE;
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            if (LOAD_STALL_CYCLES > 1) begin
                ld_rd_nxt = bus.rd_ex;
                cnt_nxt   = 2'(LOAD_STALL_CYCLES - 2);
                state_nxt = LOAD_STALL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 2'd0;
            ld_rd <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ld_rd <= ld_rd_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= 16'd0;
        else if (bus.ctrl_select == CTRL_BUBBLE && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end

    assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed checks of hazard_ctrl_unit with N=1 (a) and N=3 (b) side by side.
module tb_hazard_ctrl_unit;
    import hazard_ctrl_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_ADDR_W(5)) ifa ();
    hazard_ctrl_unit_if #(.REG_ADDR_W(5)) ifb ();

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rs1, rs2, uses_rs1, uses_rs2, rd, memRead, branch, jump
    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2,
                          input logic [4:0] rd, input logic mr,
                          input logic bt, input logic jp);
        ifa.rs1_id = r1;          ifb.rs1_id = r1;
        ifa.rs2_id = r2;          ifb.rs2_id = r2;
        ifa.uses_rs1_id = u1;     ifb.uses_rs1_id = u1;
        ifa.uses_rs2_id = u2;     ifb.uses_rs2_id = u2;
        ifa.rd_ex = rd;           ifb.rd_ex = rd;
        ifa.memRead_ex = mr;      ifb.memRead_ex = mr;
        ifa.branch_taken_ex = bt; ifb.branch_taken_ex = bt;
        ifa.jump_ex = jp;         ifb.jump_ex = jp;
    endtask

    // next cycle: apply inputs on the falling edge, settle, then check
    task automatic cyc(input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr,
                       input logic bt, input logic jp);
        @(negedge clk);
        set_in(r1, r2, u1, u2, rd, mr, bt, jp);
        #1;
    endtask

    task automatic idle();
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_use();
        cyc(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_a_ctrl", 16'(ifa.ctrl_select), 16'd0);
        chk("rst_a_pcw", 16'(ifa.pc_write), 16'd0);
        chk("rst_a_ifw", 16'(ifa.ifid_write), 16'd0);
        chk("rst_a_cnt", ifa.stall_count, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("run_a_ctrl", 16'(ifa.ctrl_select), 16'd1);
        chk("run_a_pcw", 16'(ifa.pc_write), 16'd1);
        chk("run_a_flush", 16'(ifa.ifid_flush), 16'd0);
        chk("run_a_src", 16'(ifa.pc_src_sel), 16'd0);

        // load-use, rd=5 via rs2
        load_use();
        chk("lu_a_ctrl", 16'(ifa.ctrl_select), 16'd0);
        chk("lu_a_pcw", 16'(ifa.pc_write), 16'd0);
        chk("lu_a_ifw", 16'(ifa.ifid_write), 16'd0);
        chk("lu_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        chk("lu_a_cnt_lag", ifa.stall_count, 16'd0);
        idle();
        chk("lu1_a_ctrl", 16'(ifa.ctrl_select), 16'd1);
        chk("lu1_a_pcw", 16'(ifa.pc_write), 16'd1);
        chk("lu1_a_ifw", 16'(ifa.ifid_write), 16'd1);
        chk("lu1_a_cnt", ifa.stall_count, 16'd1);
        chk("lu1_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        chk("lu1_b_pcw", 16'(ifb.pc_write), 16'd0);
        idle();
        chk("lu2_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        idle();
        chk("lu3_b_ctrl", 16'(ifb.ctrl_select), 16'd1);
        chk("lu3_b_cnt", ifb.stall_count, 16'd3);

        // x0 and unused source never stall; rs1 match does
        cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("x0_a_ctrl", 16'(ifa.ctrl_select), 16'd1);
        chk("x0_b_ctrl", 16'(ifb.ctrl_select), 16'd1);
        cyc(5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("unused_a_ctrl", 16'(ifa.ctrl_select), 16'd1);
        chk("unused_b_ctrl", 16'(ifb.ctrl_select), 16'd1);
        cyc(5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("rs1_a_ctrl", 16'(ifa.ctrl_select), 16'd0);
        chk("rs1_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        idle();
        chk("rs1_1_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        idle();
        idle();
        chk("rs1_3_b_ctrl", 16'(ifb.ctrl_select), 16'd1);
        chk("rs1_a_cnt", ifa.stall_count, 16'd2);
        chk("rs1_b_cnt", ifb.stall_count, 16'd6);

        // branch coincident with hazard: flush wins
        cyc(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        chk("br_a_flush", 16'(ifa.ifid_flush), 16'd1);
        chk("br_a_src", 16'(ifa.pc_src_sel), 16'd1);
        chk("br_a_ctrl", 16'(ifa.ctrl_select), 16'd0);
        chk("br_a_pcw", 16'(ifa.pc_write), 16'd1);
        chk("br_a_ifw", 16'(ifa.ifid_write), 16'd1);
        chk("br_b_flush", 16'(ifb.ifid_flush), 16'd1);
        chk("br_b_pcw", 16'(ifb.pc_write), 16'd1);
        idle();
        chk("br1_b_ctrl", 16'(ifb.ctrl_select), 16'd1);
        chk("br1_a_ctrl", 16'(ifa.ctrl_select), 16'd1);
        chk("br1_a_cnt", ifa.stall_count, 16'd3);
        chk("br1_b_cnt", ifb.stall_count, 16'd7);

        // jump in second stall cycle aborts the N=3 stall
        load_use();
        chk("jp0_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("jp_b_flush", 16'(ifb.ifid_flush), 16'd1);
        chk("jp_b_src", 16'(ifb.pc_src_sel), 16'd1);
        chk("jp_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        chk("jp_b_pcw", 16'(ifb.pc_write), 16'd1);
        chk("jp_b_ifw", 16'(ifb.ifid_write), 16'd1);
        idle();
        chk("jp1_b_ctrl", 16'(ifb.ctrl_select), 16'd1);
        chk("jp1_b_state", 16'(u_b.state), 16'(RUN));
        chk("jp1_a_cnt", ifa.stall_count, 16'd5);
        chk("jp1_b_cnt", ifb.stall_count, 16'd9);

        // back-to-back hazards
        load_use();
        chk("bb0_a_ctrl", 16'(ifa.ctrl_select), 16'd0);
        load_use();
        chk("bb1_a_ctrl", 16'(ifa.ctrl_select), 16'd0);
        chk("bb1_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        idle();
        chk("bb2_a_ctrl", 16'(ifa.ctrl_select), 16'd1);
        chk("bb2_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        idle();
        chk("bb3_b_ctrl", 16'(ifb.ctrl_select), 16'd1);
        load_use();
        chk("bb4_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        idle();
        chk("bb5_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        idle();
        chk("bb6_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        idle();
        chk("bb7_b_ctrl", 16'(ifb.ctrl_select), 16'd1);
        chk("bb7_a_cnt", ifa.stall_count, 16'd8);
        chk("bb7_b_cnt", ifb.stall_count, 16'd15);

        // reset with N=3 mid-stall, cnt=1
        load_use();
        idle();
        chk("mid_b_cnt1", 16'(u_b.cnt), 16'd1);
        rst = 1'b1;
        #1;
        chk("mrst_b_ctrl", 16'(ifb.ctrl_select), 16'd0);
        chk("mrst_b_pcw", 16'(ifb.pc_write), 16'd0);
        chk("mrst_b_ifw", 16'(ifb.ifid_write), 16'd0);
        chk("mrst_b_flush", 16'(ifb.ifid_flush), 16'd0);
        chk("mrst_b_src", 16'(ifb.pc_src_sel), 16'd0);
        chk("mrst_b_cnt", ifb.stall_count, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("post_b_state", 16'(u_b.state), 16'(RUN));
        chk("post_b_ctrl", 16'(ifb.ctrl_select), 16'd1);
        chk("post_b_cnt", ifb.stall_count, 16'd0);
        chk("post_a_cnt", ifa.stall_count, 16'd0);

        // saturation: continuous hazard
        load_use();
        repeat (65540) @(negedge clk);
        #1;
        chk("sat_a_cnt", ifa.stall_count, 16'hFFFF);
        chk("sat_b_cnt", ifb.stall_count, 16'hFFFF);
        @(negedge clk);
        #1;
        chk("sat_a_hold", ifa.stall_count, 16'hFFFF);
        chk("sat_a_ctrl", 16'(ifa.ctrl_select), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
